scs_ocp_target: RTL and testbench

OCP slave target that terminates the sequencer unit's OCP master port (mcmd/mbyten/maddr/mdata out, sdata/sresp/scmdaccept back). It holds a small bank of 16-bit byte-writable registers exposed as a flat bus to application logic. Accept is delayed by a programmable number of wait states. Every accepted command, read or write, gets exactly one response. It is the bench-and-silicon responder the sequencer talks to over its external bus.

---
 rtl/scs_ocp_pkg.sv | 19 +
 rtl/scs_ocp_regbank.sv | 54 +++++
 rtl/scs_ocp_target.sv | 135 +++++++++++++
 tb/tb_scs_ocp_target.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scs_ocp_pkg.sv
// Shared OCP command/response encodings and target FSM state type.
// Used by both the target and the sequencer-side OCP master wrapper.
package scs_ocp_pkg;

    localparam logic [2:0] MCMD_IDLE = 3'd0;
    localparam logic [2:0] MCMD_WR   = 3'd1;
    localparam logic [2:0] MCMD_RD   = 3'd2;

    localparam logic [1:0] SRESP_NULL = 2'd0;
    localparam logic [1:0] SRESP_DVA  = 2'd1;
    localparam logic [1:0] SRESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ocp_state_e;

endpackage

// File: rtl/scs_ocp_regbank.sv
// Byte-writable 16-bit register array with a read-only write counter in the
// top slot and a combinational read mux.
module scs_ocp_regbank #(
    parameter int NREGS = 16,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [1:0]            wr_byten,
    input  logic [15:0]           wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [15:0]           rd_data,
    output logic [16*NREGS-1:0]   regs_out
);

    logic [15:0] wr_count;

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        logic [15:0] q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (wr_en && wr_idx == IDX_W'(i)) begin
                if (wr_byten[0]) q[7:0]  <= wr_data[7:0];
                if (wr_byten[1]) q[15:8] <= wr_data[15:8];
            end
        end

        assign regs_out[16*i +: 16] = q;
    end

    // Every in-range write counts, including empty byte enables and writes
    // aimed at the counter slot itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    assign regs_out[16*(NREGS-1) +: 16] = wr_count;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = regs_out[16*i +: 16];
        end
    end

endmodule

// File: rtl/scs_ocp_target.sv
// OCP slave target: wait-state accept FSM, one registered response per
// accepted command, and a register bank exposed to application logic.
//
// state   | meaning
// IDLE    | no command pending; accepts at once when WAIT_CYCLES = 0
// WAIT    | command pending, wait counter running down to accept
// RESP    | registered response driven for this single cycle
module scs_ocp_target #(
    parameter int          NREGS       = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [12:0] BASE_ADDR   = 13'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            ocp_s_mcmd,
    input  logic [1:0]            ocp_s_mbyten,
    input  logic [12:0]           ocp_s_maddr,
    input  logic [15:0]           ocp_s_mdata,
    output logic                  ocp_s_scmdaccept,
    output logic [1:0]            ocp_s_sresp,
    output logic [15:0]           ocp_s_sdata,
    output logic [16*NREGS-1:0]   regs_out
);

    import scs_ocp_pkg::*;

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    ocp_state_e state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [1:0]  sresp_q, sresp_d;
    logic [15:0] sdata_q, sdata_d;

    logic        cmd_valid;
    logic        is_wr;
    logic        is_rd;
    logic [12:0] offset;
    logic        in_range;
    logic        accept;
    logic        accept_live;
    logic [15:0] rd_data;

    assign cmd_valid = (ocp_s_mcmd != MCMD_IDLE);
    assign is_wr     = (ocp_s_mcmd == MCMD_WR);
    assign is_rd     = (ocp_s_mcmd == MCMD_RD);
    assign offset    = ocp_s_maddr - BASE_ADDR;
    assign in_range  = (offset < 13'(NREGS));

    // Reset masks the accept so a command coinciding with rst has no effect.
    assign accept_live = accept & ~rst;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        sresp_d = SRESP_NULL;
        sdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        accept  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cmd_valid) begin
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else if (wait_q == '0) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            if (is_wr && in_range) begin
                sresp_d = SRESP_DVA;
            end else if (is_rd && in_range) begin
                sresp_d = SRESP_DVA;
                sdata_d = rd_data;
            end else begin
                sresp_d = SRESP_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            sresp_q <= SRESP_NULL;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sresp_q <= sresp_d;
            sdata_q <= sdata_d;
        end
    end

    scs_ocp_regbank #(
        .NREGS (NREGS)
    ) u_regbank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept_live && is_wr && in_range),
        .wr_idx   (offset[IDX_W-1:0]),
        .wr_byten (ocp_s_mbyten),
        .wr_data  (ocp_s_mdata),
        .rd_idx   (offset[IDX_W-1:0]),
        .rd_data  (rd_data),
        .regs_out (regs_out)
    );

    assign ocp_s_scmdaccept = accept_live;
    assign ocp_s_sresp      = sresp_q;
    assign ocp_s_sdata      = sdata_q;

endmodule

// File: tb/tb_scs_ocp_target.sv
// Bench for scs_ocp_target: a zero-wait-state and a three-wait-state instance
// checked with a directed vector table, hand sequences and random traffic.
module tb_scs_ocp_target;

    import scs_ocp_pkg::*;

    localparam int          N0 = 16;
    localparam int          N1 = 8;
    localparam logic [12:0] B1 = 13'h0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  mcmd  [2];
    logic [1:0]  byten [2];
    logic [12:0] maddr [2];
    logic [15:0] mdata [2];
    logic        acc   [2];
    logic [1:0]  sresp [2];
    logic [15:0] sdata [2];
    logic [16*N0-1:0] regs0;
    logic [16*N1-1:0] regs1;

    scs_ocp_target #(.NREGS(N0), .WAIT_CYCLES(0), .BASE_ADDR(13'h0000)) dut0 (
        .clk(clk), .rst(rst),
        .ocp_s_mcmd(mcmd[0]), .ocp_s_mbyten(byten[0]), .ocp_s_maddr(maddr[0]),
        .ocp_s_mdata(mdata[0]), .ocp_s_scmdaccept(acc[0]), .ocp_s_sresp(sresp[0]),
        .ocp_s_sdata(sdata[0]), .regs_out(regs0)
    );

    scs_ocp_target #(.NREGS(N1), .WAIT_CYCLES(3), .BASE_ADDR(B1)) dut1 (
        .clk(clk), .rst(rst),
        .ocp_s_mcmd(mcmd[1]), .ocp_s_mbyten(byten[1]), .ocp_s_maddr(maddr[1]),
        .ocp_s_mdata(mdata[1]), .ocp_s_scmdaccept(acc[1]), .ocp_s_sresp(sresp[1]),
        .ocp_s_sdata(sdata[1]), .regs_out(regs1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: plain register contents per instance.
    logic [15:0] mdl [2][64];
    int          nregs [2] = '{N0, N1};
    logic [12:0] base  [2] = '{13'h0000, B1};
    int          waits [2] = '{0, 3};

    typedef struct {
        int          d;
        logic [2:0]  c;
        logic [12:0] a;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [1:0]  er;
        logic [15:0] ed;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) mdl[d][i] = 16'h0000;
    endtask

    task automatic check_regs(input int d, input string name);
        logic [15:0] a;
        int bad;
        bad = -1;
        for (int i = 0; i < nregs[d]; i++) begin
            a = (d == 0) ? regs0[16*i +: 16] : 16'(regs1 >> (16*i));
            if (a !== mdl[d][i] && bad < 0) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            a = (d == 0) ? regs0[16*bad +: 16] : 16'(regs1 >> (16*bad));
            $display("FAIL %s: dut%0d r[%0d] got %h expected %h", name, d, bad, a, mdl[d][bad]);
        end
    endtask

    // Applies one accepted command to the model and returns the response it implies.
    task automatic model(input int d, input logic [2:0] c, input logic [12:0] a,
                         input logic [1:0] be, input logic [15:0] wd,
                         output logic [1:0] r, output logic [15:0] rd);
        logic [12:0] o13;
        int off, n;
        o13 = a - base[d];
        off = int'(o13);
        n = nregs[d];
        r = SRESP_ERR;
        rd = 16'h0000;
        if (c == MCMD_WR && off < n) begin
            if (off < n - 1) begin
                if (be[0]) mdl[d][off][7:0]  = wd[7:0];
                if (be[1]) mdl[d][off][15:8] = wd[15:8];
            end
            mdl[d][n-1] = mdl[d][n-1] + 16'd1;
            r = SRESP_DVA;
        end else if (c == MCMD_RD && off < n) begin
            r = SRESP_DVA;
            rd = mdl[d][off];
        end
    endtask

    // Called at a negedge; returns after the cycle following the response.
    task automatic do_txn(input int d, input logic [2:0] c, input logic [12:0] a,
                          input logic [1:0] be, input logic [15:0] wd,
                          output int lat, output logic [1:0] r, output logic [15:0] rd);
        lat = -1;
        r = 2'b00;
        rd = 16'h0000;
        mcmd[d] = c; maddr[d] = a; byten[d] = be; mdata[d] = wd;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (acc[d]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut%0d no accept within 40 cycles", d);
            mcmd[d] = MCMD_IDLE;
            @(negedge clk);
            return;
        end
        @(negedge clk);
        #1;
        r = sresp[d];
        rd = sdata[d];
        check("no_accept_in_resp", 32'(acc[d]), 32'd0);
        mcmd[d] = MCMD_IDLE;
        @(negedge clk);
        #1;
        check("resp_one_cycle", {14'd0, sresp[d], sdata[d]}, 32'd0);
    endtask

    task automatic exec(input int d, input logic [2:0] c, input logic [12:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        input logic [1:0] er, input logic [15:0] ed,
                        input bit apply, input string tag);
        int lat;
        logic [1:0] r, mr;
        logic [15:0] rd, md;
        do_txn(d, c, a, be, wd, lat, r, rd);
        if (apply) model(d, c, a, be, wd, mr, md);
        check({tag, "_latency"}, 32'(lat), 32'(waits[d]));
        check({tag, "_sresp"}, 32'(r), 32'(er));
        check({tag, "_sdata"}, 32'(rd), 32'(ed));
        check_regs(d, {tag, "_regs"});
    endtask

    task automatic add(input int d, input logic [2:0] c, input logic [12:0] a, input logic [1:0] be,
                       input logic [15:0] wd, input logic [1:0] er, input logic [15:0] ed);
        vec_t v;
        v.d = d; v.c = c; v.a = a; v.be = be; v.wd = wd; v.er = er; v.ed = ed;
        vt.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  er;
        logic [15:0] ed;
        logic [2:0]  c;
        logic [12:0] a;
        int          seen;
        int          sel;

        for (int d = 0; d < 2; d++) begin
            mcmd[d] = MCMD_IDLE; byten[d] = 2'b00; maddr[d] = '0; mdata[d] = '0;
        end
        model_reset();

        // Reset with a command presented: no accept, everything at zero.
        rst = 1'b1;
        mcmd[0] = MCMD_WR; maddr[0] = 13'd3; byten[0] = 2'b11; mdata[0] = 16'hDEAD;
        mcmd[1] = MCMD_WR; maddr[1] = B1;    byten[1] = 2'b11; mdata[1] = 16'hDEAD;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_accept", 32'(acc[d]), 32'd0);
            check("reset_sresp", 32'(sresp[d]), 32'd0);
            check("reset_sdata", 32'(sdata[d]), 32'd0);
            check_regs(d, "reset_regs");
            mcmd[d] = MCMD_IDLE;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        add(0, MCMD_WR, 13'd3,  2'b11, 16'hA5C3, SRESP_DVA, 16'h0000);
        add(0, MCMD_RD, 13'd3,  2'b11, 16'h0000, SRESP_DVA, 16'hA5C3);
        add(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0001);
        add(0, MCMD_WR, 13'd3,  2'b10, 16'h1234, SRESP_DVA, 16'h0000);
        add(0, MCMD_RD, 13'd3,  2'b00, 16'h0000, SRESP_DVA, 16'h12C3);
        add(0, MCMD_WR, 13'd3,  2'b00, 16'hFFFF, SRESP_DVA, 16'h0000);
        add(0, MCMD_RD, 13'd3,  2'b11, 16'h0000, SRESP_DVA, 16'h12C3);
        add(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0003);
        add(0, MCMD_RD, 13'd16, 2'b11, 16'h0000, SRESP_ERR, 16'h0000);
        add(0, 3'd5,    13'd3,  2'b11, 16'h7777, SRESP_ERR, 16'h0000);
        add(0, MCMD_WR, 13'd15, 2'b11, 16'hBEEF, SRESP_DVA, 16'h0000);
        add(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0004);
        add(0, MCMD_WR, 13'd16, 2'b11, 16'h1111, SRESP_ERR, 16'h0000);
        add(0, 3'd3,    13'd0,  2'b11, 16'h2222, SRESP_ERR, 16'h0000);
        add(0, 3'd7,    13'd1,  2'b11, 16'h3333, SRESP_ERR, 16'h0000);
        add(0, MCMD_WR, 13'd0,  2'b01, 16'hAAFF, SRESP_DVA, 16'h0000);
        add(0, MCMD_RD, 13'd0,  2'b11, 16'h0000, SRESP_DVA, 16'h00FF);
        add(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0005);
        add(1, MCMD_RD, 13'h100, 2'b11, 16'h0000, SRESP_DVA, 16'h0000);
        add(1, MCMD_WR, 13'h105, 2'b11, 16'hBEEF, SRESP_DVA, 16'h0000);
        add(1, MCMD_RD, 13'h105, 2'b11, 16'h0000, SRESP_DVA, 16'hBEEF);
        add(1, MCMD_RD, 13'h0FF, 2'b11, 16'h0000, SRESP_ERR, 16'h0000);
        add(1, MCMD_RD, 13'h108, 2'b11, 16'h0000, SRESP_ERR, 16'h0000);
        add(1, MCMD_RD, 13'h107, 2'b11, 16'h0000, SRESP_DVA, 16'h0001);
        add(1, MCMD_WR, 13'h107, 2'b11, 16'h0000, SRESP_DVA, 16'h0000);
        add(1, MCMD_RD, 13'h107, 2'b11, 16'h0000, SRESP_DVA, 16'h0002);

        foreach (vt[i]) begin
            exec(vt[i].d, vt[i].c, vt[i].a, vt[i].be, vt[i].wd, vt[i].er, vt[i].ed, 1'b1, "vec");
        end

        // Command withdrawn during wait states: no accept, no response, back to IDLE.
        mcmd[1] = MCMD_RD; maddr[1] = 13'h105; byten[1] = 2'b11;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) mcmd[1] = MCMD_IDLE;
            #1;
            if (acc[1] || sresp[1] != SRESP_NULL) seen = 1;
            @(negedge clk);
        end
        check("abort_no_accept_or_resp", 32'(seen), 32'd0);
        exec(1, MCMD_RD, 13'h105, 2'b11, 16'h0000, SRESP_DVA, 16'hBEEF, 1'b1, "after_abort");

        // Counter wrap from 16'hFFFF.
        force dut0.u_regbank.wr_count = 16'hFFFF;
        @(negedge clk);
        release dut0.u_regbank.wr_count;
        mdl[0][N0-1] = 16'hFFFF;
        check_regs(0, "wrap_preload");
        exec(0, MCMD_WR, 13'd5, 2'b11, 16'h5A5A, SRESP_DVA, 16'h0000, 1'b1, "wrap_wr");
        exec(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0000, 1'b1, "wrap_rd");

        // Reset asserted in the response cycle.
        mcmd[0] = MCMD_WR; maddr[0] = 13'd2; byten[0] = 2'b11; mdata[0] = 16'h5555;
        #1;
        check("rstmid_accept", 32'(acc[0]), 32'd1);
        @(negedge clk);
        mcmd[0] = MCMD_IDLE;
        rst = 1'b1;
        @(negedge clk);
        #1;
        model_reset();
        check("rstmid_sresp", 32'(sresp[0]), 32'd0);
        check("rstmid_sdata", 32'(sdata[0]), 32'd0);
        check_regs(0, "rstmid_regs");
        check_regs(1, "rstmid_regs1");
        mcmd[0] = MCMD_WR; maddr[0] = 13'd1; mdata[0] = 16'hFFFF;
        #1;
        check("rst_gate_accept", 32'(acc[0]), 32'd0);
        @(negedge clk);
        mcmd[0] = MCMD_IDLE;
        rst = 1'b0;
        #1;
        check_regs(0, "rst_no_write");
        @(negedge clk);
        exec(0, MCMD_WR, 13'd1, 2'b11, 16'hC0DE, SRESP_DVA, 16'h0000, 1'b1, "post_rst_wr");
        exec(0, MCMD_RD, 13'd15, 2'b11, 16'h0000, SRESP_DVA, 16'h0001, 1'b1, "post_rst_cnt");

        // Random traffic against the model.
        for (int t = 0; t < 300; t++) begin
            int d;
            d = t % 2;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) c = MCMD_WR;
            else if (sel < 8) c = MCMD_RD;
            else c = 3'($urandom_range(3, 7));
            if ($urandom_range(0, 9) == 0) a = 13'($urandom);
            else a = base[d] + 13'($urandom_range(0, nregs[d] + 2));
            begin
                logic [1:0]  be;
                logic [15:0] wd;
                be = 2'($urandom);
                wd = 16'($urandom);
                model(d, c, a, be, wd, er, ed);
                exec(d, c, a, be, wd, er, ed, 1'b0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
